mmio_fifo_port: RTL and testbench

//  Memory-mapped I/O responder on the processor's data bus (ADDR/DOUT/W, read data back on DIN).
//  It decodes a 4-word window and buffers traffic in two FIFOs:
//   - TX FIFO: filled by processor writes, drained by an external consumer through a valid/ready handshake.
//   - RX FIFO: filled by an external producer, drained by processor reads.

---
 rtl/mmio_fifo_port.sv | 96 +++++++++
 tb/tb_mmio_fifo_port.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_port.sv
// mmio_fifo_port: 4-word MMIO window with a TX FIFO (cpu->consumer) and RX FIFO (producer->cpu); ports: bus addr/wdata/wr/rd -> q/io_hit, tx valid/ready out, rx valid/ready in
module mmio_fifo_port #(
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] q,
  output logic        io_hit,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [15:0] tx_mem [DEPTH];
  logic [15:0] rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_ovf, rx_unf;
  logic hit, tx_empty, tx_full, rx_empty, rx_full;
  logic wr_tx, wr_ctrl, rd_rx, tx_flush, rx_flush, clr;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [15:0] status, rdata;
  assign hit      = addr[7:2] == BASE_ADDR[7:2];
  assign tx_empty = tx_count == '0;
  assign tx_full  = tx_count == CW'(DEPTH);
  assign rx_empty = rx_count == '0;
  assign rx_full  = rx_count == CW'(DEPTH);
  assign wr_tx    = wr & hit & (addr[1:0] == 2'd0);
  assign wr_ctrl  = wr & hit & (addr[1:0] == 2'd3);
  assign rd_rx    = rd & hit & (addr[1:0] == 2'd1);
  assign tx_flush = wr_ctrl & wdata[0];
  assign rx_flush = wr_ctrl & wdata[1];
  assign clr      = wr_ctrl & wdata[2];
  assign tx_valid = !tx_empty & !reset;
  assign rx_ready = !rx_full & !reset;
  assign tx_data  = tx_mem[tx_rp];
  // a push into a full TX FIFO is judged on the pre-edge count, so a same-cycle pop cannot make room
  assign tx_push  = wr_tx & !tx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_rx & !rx_empty;
  assign status   = {4'(rx_count), 4'(tx_count), 2'b00, rx_unf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};
  always_comb
    rdata = addr[1:0] == 2'd1 ? (rx_empty ? 16'h0 : rx_mem[rx_rp]) :
            addr[1:0] == 2'd2 ? status : 16'h0;
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end
  always_ff @(posedge clk)
    if (reset) begin
      q        <= '0;
      io_hit   <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_unf   <= 1'b0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      q      <= rd & hit ? rdata : 16'h0;
      io_hit <= hit;
      // a new event in the same cycle as a clear keeps the flag set
      tx_ovf <= (wr_tx & tx_full) | (tx_ovf & !clr);
      rx_unf <= (rd_rx & rx_empty) | (rx_unf & !clr);
      if (tx_flush) begin
        tx_wp    <= '0;
        tx_rp    <= '0;
        tx_count <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + DEPTH_LOG2'(1);
        if (tx_pop) tx_rp <= tx_rp + DEPTH_LOG2'(1);
        tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      end
      if (rx_flush) begin
        rx_wp    <= '0;
        rx_rp    <= '0;
        rx_count <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + DEPTH_LOG2'(1);
        if (rx_pop) rx_rp <= rx_rp + DEPTH_LOG2'(1);
        rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      end
    end
endmodule

// File: tb/tb_mmio_fifo_port.sv
// tb_mmio_fifo_port: self-checking bench for mmio_fifo_port
module tb_mmio_fifo_port;
  logic clk = 0, reset = 1;
  logic [7:0] addr = '0;
  logic [15:0] wdata = '0, rx_data = '0;
  logic wr = 0, rd = 0, tx_ready = 0, rx_valid = 0;
  logic [15:0] q, tx_data;
  logic io_hit, tx_valid, rx_ready;
  int total = 0, bad = 0;
  logic [15:0] exp_q [$];
  logic [15:0] tx_model [$];

  mmio_fifo_port dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
    .q(q), .io_hit(io_hit), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  a;
    logic        w;
    logic [15:0] d;
    logic        r;
    logic        tr;
    logic [15:0] eq;
    logic        ehit;
    logic        etxv;
    logic [15:0] etxd;
  } vec_t;
  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic bus(input logic [7:0] a, input logic w, input logic [15:0] d, input logic r, input logic [15:0] e);
    addr = a; wr = w; wdata = d; rd = r;
    if (r) exp_q.push_back(e);
    step();
    wr = 0; rd = 0;
    if (r) chk("q", q, exp_q.pop_front());
  endtask

  initial begin
    vecs[0]  = '{8'hF2, 0, 16'h0,    1, 0, 16'h0005, 1, 0, 16'h0};
    vecs[1]  = '{8'hF0, 1, 16'hA5A5, 0, 0, 16'h0000, 1, 1, 16'hA5A5};
    vecs[2]  = '{8'hF2, 0, 16'h0,    1, 0, 16'h0104, 1, 1, 16'hA5A5};
    vecs[3]  = '{8'hF0, 0, 16'h0,    1, 1, 16'h0000, 1, 0, 16'h0};
    vecs[4]  = '{8'h10, 0, 16'h0,    1, 0, 16'h0000, 0, 0, 16'h0};
    vecs[5]  = '{8'hF2, 0, 16'h0,    1, 0, 16'h0005, 1, 0, 16'h0};
    vecs[6]  = '{8'h10, 1, 16'h1111, 0, 0, 16'h0000, 0, 0, 16'h0};
    vecs[7]  = '{8'hF2, 0, 16'h0,    1, 0, 16'h0005, 1, 0, 16'h0};
    vecs[8]  = '{8'hF3, 0, 16'h0,    1, 0, 16'h0000, 1, 0, 16'h0};
    vecs[9]  = '{8'hF2, 1, 16'hFFFF, 0, 0, 16'h0000, 1, 0, 16'h0};
    vecs[10] = '{8'hF2, 0, 16'h0,    1, 0, 16'h0005, 1, 0, 16'h0};
    #1;
    step();
    chk("rx_ready_in_reset", rx_ready, 0);
    chk("tx_valid_in_reset", tx_valid, 0);
    step();
    reset = 0;
    #1;
    chk("rx_ready_after_reset", rx_ready, 1);
    chk("q_after_reset", q, 0);
    chk("io_hit_after_reset", io_hit, 0);

    for (int i = 0; i < 11; i++) begin
      addr = vecs[i].a; wr = vecs[i].w; wdata = vecs[i].d; rd = vecs[i].r; tx_ready = vecs[i].tr;
      exp_q.push_back(vecs[i].eq);
      step();
      wr = 0; rd = 0; tx_ready = 0;
      chk($sformatf("vec%0d_q", i), q, exp_q.pop_front());
      chk($sformatf("vec%0d_io_hit", i), io_hit, vecs[i].ehit);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].etxv);
      if (vecs[i].etxv) chk($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].etxd);
    end

    // TX overflow and ordered drain
    for (int i = 0; i < 9; i++) begin
      logic [15:0] d;
      d = i == 8 ? 16'h9999 : 16'h1000 + 16'(i);
      if (tx_model.size() < 8) tx_model.push_back(d);
      bus(8'hF0, 1, d, 0, 0);
    end
    bus(8'hF2, 0, 0, 1, 16'h0816);
    chk("tx_valid_full", tx_valid, 1);
    tx_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid) break;
      chk("tx_drain_data", tx_data, tx_model.pop_front());
      step();
    end
    tx_ready = 0;
    chk("tx_drain_left", 16'(tx_model.size()), 0);
    chk("tx_valid_drained", tx_valid, 0);
    bus(8'hF2, 0, 0, 1, 16'h0015);
    bus(8'hF3, 1, 16'h0004, 0, 0);
    bus(8'hF2, 0, 0, 1, 16'h0005);

    // RX push/pop and underflow
    rx_valid = 1; rx_data = 16'h1234; step();
    rx_data = 16'h5678; step();
    rx_valid = 0;
    bus(8'hF1, 0, 0, 1, 16'h1234);
    bus(8'hF1, 0, 0, 1, 16'h5678);
    bus(8'hF1, 0, 0, 1, 16'h0000);
    bus(8'hF2, 0, 0, 1, 16'h0025);
    bus(8'hF3, 1, 16'h0004, 0, 0);

    // RX fill to full with producer still offering
    rx_valid = 1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'hC000 + 16'(i);
      step();
    end
    chk("rx_ready_full", rx_ready, 0);
    rx_data = 16'hDEAD; step();
    chk("rx_ready_still_full", rx_ready, 0);
    rx_valid = 0;
    bus(8'hF2, 0, 0, 1, 16'h8009);
    for (int i = 0; i < 8; i++) bus(8'hF1, 0, 0, 1, 16'hC000 + 16'(i));
    bus(8'hF2, 0, 0, 1, 16'h0005);

    // TX flush with simultaneous consumer pop
    for (int i = 0; i < 3; i++) bus(8'hF0, 1, 16'h0A00 + 16'(i), 0, 0);
    chk("tx_valid_3", tx_valid, 1);
    addr = 8'hF3; wr = 1; wdata = 16'h0001; tx_ready = 1;
    step();
    wr = 0; tx_ready = 0;
    chk("tx_valid_flushed", tx_valid, 0);
    bus(8'hF2, 0, 0, 1, 16'h0005);

    // reset mid-operation with RX holding data
    rx_valid = 1; rx_data = 16'h7777; step(); step();
    rx_valid = 0;
    bus(8'hF2, 0, 0, 1, 16'h2001);
    addr = 8'hF2; rd = 1; reset = 1;
    step();
    rd = 0;
    chk("rx_ready_mid_reset", rx_ready, 0);
    chk("q_mid_reset", q, 0);
    chk("io_hit_mid_reset", io_hit, 0);
    reset = 0;
    #1;
    chk("rx_ready_post_reset", rx_ready, 1);
    bus(8'hF2, 0, 0, 1, 16'h0005);
    bus(8'hF1, 0, 0, 1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
